// File: rtl/sram_controller.sv
// Multi-cycle data-memory port: each 32-bit load/store becomes two 16-bit phases on an async SRAM.
// Request seen in IDLE at cycle 0, ready=1 in cycle 2*WAIT_CYCLES+1; ready=0 freezes the core until then.
module sram_controller #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned SRAM_ADDR_W = 18,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rd_en,
   input  logic                   wr_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   inout  wire  [15:0]            SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_OE_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_LO,
      WR_HI,
      RD_LO,
      RD_HI,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [15:0]            lo_buf_q, lo_buf_d;
   logic [31:0]            rdata_q, rdata_d;

   logic                   last_phase;
   logic                   dq_oe;
   logic [15:0]            dq_out;
   logic [SRAM_ADDR_W-1:0] lo_addr;

   // Word index relative to BASE_ADDR, doubled to a halfword address; wraps modulo 2^32 then truncates.
   assign lo_addr    = SRAM_ADDR_W'(((address - 32'(BASE_ADDR)) >> 2) << 1);
   assign last_phase = (cnt_q == CNT_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      lo_buf_d  = lo_buf_q;
      rdata_d   = rdata_q;
      ready     = 1'b0;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      dq_oe     = 1'b0;
      dq_out    = 16'h0000;

      case (state_q)
         IDLE: begin
            ready = ~(rd_en | wr_en);
            cnt_d = '0;
            if (wr_en) begin
               state_d = WR_LO;
               addr_d  = lo_addr;
               wdata_d = write_data;
            end else if (rd_en) begin
               state_d = RD_LO;
               addr_d  = lo_addr;
            end
         end
         WR_LO: begin
            SRAM_WE_N = 1'b0;
            dq_oe     = 1'b1;
            dq_out    = wdata_q[15:0];
            cnt_d     = cnt_q + CNT_W'(1);
            if (last_phase) begin
               cnt_d   = '0;
               state_d = WR_HI;
               addr_d  = {addr_q[SRAM_ADDR_W-1:1], 1'b1};
            end
         end
         WR_HI: begin
            SRAM_WE_N = 1'b0;
            dq_oe     = 1'b1;
            dq_out    = wdata_q[31:16];
            cnt_d     = cnt_q + CNT_W'(1);
            if (last_phase) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         RD_LO: begin
            SRAM_OE_N = 1'b0;
            cnt_d     = cnt_q + CNT_W'(1);
            if (last_phase) begin
               cnt_d    = '0;
               lo_buf_d = SRAM_DQ;
               state_d  = RD_HI;
               addr_d   = {addr_q[SRAM_ADDR_W-1:1], 1'b1};
            end
         end
         RD_HI: begin
            SRAM_OE_N = 1'b0;
            cnt_d     = cnt_q + CNT_W'(1);
            if (last_phase) begin
               cnt_d   = '0;
               rdata_d = {SRAM_DQ, lo_buf_q};
               state_d = DONE;
            end
         end
         DONE: begin
            // Pipeline advances on this edge; requests are deliberately not sampled here.
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         lo_buf_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         lo_buf_q <= lo_buf_d;
         rdata_q  <= rdata_d;
      end
   end

   assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
   assign SRAM_ADDR = addr_q;
   assign read_data = rdata_q;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: default build checked every cycle against a transaction-level model,
// plus a WAIT_CYCLES=1 build checked for its shorter latency.
module tb_sram_controller;

   localparam int W0 = 2;
   localparam int W1 = 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- default build ----------------
   logic        rd_en, wr_en;
   logic [31:0] address, write_data, read_data;
   logic        ready, we_n, oe_n, ce_n, ub_n, lb_n;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;

   sram_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(W0)) u_dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en),
      .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
      .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
   );

   // ---------------- WAIT_CYCLES=1 build ----------------
   logic        rd1, wr1;
   logic [31:0] a1, d1, read_data1;
   logic        ready1, we_n1, oe_n1, ce_n1, ub_n1, lb_n1;
   logic [17:0] sram_addr1;
   wire  [15:0] sram_dq1;

   sram_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(W1)) u_dut1 (
      .clk(clk), .reset(reset), .rd_en(rd1), .wr_en(wr1),
      .address(a1), .write_data(d1), .read_data(read_data1), .ready(ready1),
      .SRAM_DQ(sram_dq1), .SRAM_ADDR(sram_addr1), .SRAM_WE_N(we_n1), .SRAM_OE_N(oe_n1),
      .SRAM_CE_N(ce_n1), .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1)
   );

   // ---------------- SRAM models ----------------
   // A write commits only once WE_N has been low at one address for WAIT clocks (minimum write pulse).
   logic [15:0] mem0 [0:255];
   logic [15:0] mem1 [0:255];
   logic [17:0] wa0, wa1;
   int          wcnt0 = 0, wcnt1 = 0;

   assign sram_dq  = (oe_n  === 1'b0 && we_n  === 1'b1) ? mem0[sram_addr[7:0]]  : 16'hzzzz;
   assign sram_dq1 = (oe_n1 === 1'b0 && we_n1 === 1'b1) ? mem1[sram_addr1[7:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (we_n === 1'b0) begin
         if (wcnt0 != 0 && sram_addr == wa0) wcnt0 = wcnt0 + 1;
         else begin wa0 = sram_addr; wcnt0 = 1; end
         if (wcnt0 == W0) mem0[wa0[7:0]] = sram_dq;
      end else wcnt0 = 0;
   end

   always @(posedge clk) begin
      if (we_n1 === 1'b0) begin
         if (wcnt1 != 0 && sram_addr1 == wa1) wcnt1 = wcnt1 + 1;
         else begin wa1 = sram_addr1; wcnt1 = 1; end
         if (wcnt1 == W1) mem1[wa1[7:0]] = sram_dq1;
      end else wcnt1 = 0;
   end

   // ---------------- reference model and checking ----------------
   logic [15:0] ref_mem [0:255];
   logic        chk_en = 1'b0;
   logic        exp_ready, exp_we_n, exp_oe_n, dq_chk;
   logic [15:0] exp_dq;
   logic [17:0] exp_addr;
   logic [31:0] exp_rdata;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] sram_lo(input logic [31:0] a);
      return 18'((a - 32'd1024) / 32'd4 * 32'd2);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("ready",     32'(ready),     32'(exp_ready));
         check("we_n",      32'(we_n),      32'(exp_we_n));
         check("oe_n",      32'(oe_n),      32'(exp_oe_n));
         check("sram_addr", 32'(sram_addr), 32'(exp_addr));
         check("read_data", read_data,      exp_rdata);
         check("tied_ctl",  32'({ce_n, ub_n, lb_n}), 32'd0);
         if (dq_chk) check("dq", 32'(sram_dq), 32'(exp_dq));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rd_en = 1'b0; wr_en = 1'b0;
      exp_ready = 1'b1; exp_we_n = 1'b1; exp_oe_n = 1'b1; dq_chk = 1'b0;
      repeat (n) step();
   endtask

   // One request from its IDLE cycle through DONE; enables stay asserted through DONE.
   // rst_at > 0 pulses reset during that phase clock (must lie in the high half of a write).
   task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input int rst_at);
      logic [17:0] lo;
      logic [7:0]  li, hi;
      lo = sram_lo(a);
      li = lo[7:0];
      hi = {lo[7:1], 1'b1};
      rd_en = rd; wr_en = wr; address = a; write_data = d;
      exp_ready = 1'b0; exp_we_n = 1'b1; exp_oe_n = 1'b1; dq_chk = 1'b0;
      step();
      address = ~a; write_data = ~d;
      for (int k = 1; k <= 2 * W0; k++) begin
         exp_addr = (k <= W0) ? lo : {lo[17:1], 1'b1};
         if (wr) begin
            exp_we_n = 1'b0; dq_chk = 1'b1;
            exp_dq = (k <= W0) ? d[15:0] : d[31:16];
         end else begin
            exp_oe_n = 1'b0;
         end
         if (k == rst_at) reset = 1'b1;
         step();
         if (k == rst_at) begin
            reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
            ref_mem[li] = d[15:0];
            exp_ready = 1'b1; exp_we_n = 1'b1; exp_oe_n = 1'b1; dq_chk = 1'b0;
            exp_addr = '0; exp_rdata = '0;
            return;
         end
      end
      exp_ready = 1'b1; exp_we_n = 1'b1; exp_oe_n = 1'b1; dq_chk = 1'b0;
      if (wr) begin
         ref_mem[li] = d[15:0];
         ref_mem[hi] = d[31:16];
      end else begin
         exp_rdata = {ref_mem[hi], ref_mem[li]};
      end
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem0[i] = 16'h0000; mem1[i] = 16'h0000; ref_mem[i] = 16'h0000;
      end
      mem0[2] = 16'hBEEF; ref_mem[2] = 16'hBEEF;
      mem0[3] = 16'hDEAD; ref_mem[3] = 16'hDEAD;
      rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
      rd1 = 1'b0; wr1 = 1'b0; a1 = '0; d1 = '0;
      exp_dq = '0;

      // Reset held two clocks, then checked while still asserted and after release
      reset = 1'b1;
      repeat (2) step();
      exp_ready = 1'b1; exp_we_n = 1'b1; exp_oe_n = 1'b1; dq_chk = 1'b0;
      exp_addr = '0; exp_rdata = '0;
      chk_en = 1'b1;
      step();
      reset = 1'b0;
      idle(2);

      // Store 0x12345678 at the base address
      txn(1'b0, 1'b1, 32'd1024, 32'h12345678, 0);
      idle(1);
      check("store_lo_half", 32'(mem0[0]), 32'h0000_5678);
      check("store_hi_half", 32'(mem0[1]), 32'h0000_1234);

      // Load preloaded word
      txn(1'b1, 1'b0, 32'd1028, 32'h0, 0);
      idle(1);
      check("load_word", read_data, 32'hDEADBEEF);

      // Back-to-back store then load, requests held through DONE
      txn(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 0);
      txn(1'b1, 1'b0, 32'd1032, 32'h0, 0);
      idle(1);
      check("b2b_load", read_data, 32'hCAFEF00D);

      // Both enables: write wins, read_data must not move; then read with low address bits set
      txn(1'b1, 1'b1, 32'd1036, 32'hA5A55A5A, 0);
      idle(1);
      check("both_keeps_rdata", read_data, 32'hCAFEF00D);
      txn(1'b1, 1'b0, 32'd1039, 32'h0, 0);
      idle(1);
      check("both_wrote", read_data, 32'hA5A55A5A);

      // Address below base wraps to the top of the SRAM
      txn(1'b0, 1'b1, 32'd1020, 32'h00FFFF00, 0);
      idle(1);
      check("wrap_lo_mem", 32'(mem0[8'hFE]), 32'h0000_FF00);
      txn(1'b1, 1'b0, 32'd1020, 32'h0, 0);
      idle(1);
      check("wrap_load", read_data, 32'h00FFFF00);

      // Shorter build: ready three cycles after the request, for a store then a load
      wr1 = 1'b1; a1 = 32'd1024; d1 = 32'h0BADF00D;
      for (int k = 0; k <= 2 * W1 + 1; k++) begin
         @(negedge clk);
         check("w1_wr_ready", 32'(ready1), 32'(k == 2 * W1 + 1));
         check("w1_we_n",     32'(we_n1),  32'(!(k >= 1 && k <= 2 * W1)));
         @(posedge clk); #1;
      end
      wr1 = 1'b0; rd1 = 1'b1;
      for (int k = 0; k <= 2 * W1 + 1; k++) begin
         @(negedge clk);
         check("w1_rd_ready", 32'(ready1), 32'(k == 2 * W1 + 1));
         check("w1_oe_n",     32'(oe_n1),  32'(!(k >= 1 && k <= 2 * W1)));
         @(posedge clk); #1;
      end
      rd1 = 1'b0;
      check("w1_load", read_data1, 32'h0BADF00D);
      check("w1_mem_hi", 32'(mem1[1]), 32'h0000_0BAD);

      // Reset in the first WR_HI clock: low half lands, high half keeps its old value
      txn(1'b0, 1'b1, 32'd1024, 32'h99998888, W0 + 1);
      idle(2);
      check("rst_lo_mem", 32'(mem0[0]), 32'h0000_8888);
      check("rst_hi_mem", 32'(mem0[1]), 32'h0000_1234);
      txn(1'b1, 1'b0, 32'd1024, 32'h0, 0);
      idle(1);
      check("rst_partial_load", read_data, 32'h12348888);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
